// File: rtl/lsu_ctrl_pkg.sv
// Shared widths, access-size encoding and controller state type for the load/store unit.
// Both packages live here because every LSU file needs them together.
package rysyPkg;
    localparam int unsigned REG_LEN = 32;
endpackage

package selectPkg;
    typedef enum logic [2:0] {
        SB  = 3'd0,
        SH  = 3'd1,
        SW  = 3'd2,
        SBU = 3'd3,
        SHU = 3'd4
    } sel_type;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } lsu_state_t;

    // Misaligned halfword/word, unsigned store sizes and unknown encodings are rejected.
    function automatic logic access_illegal(input sel_type t, input logic we, input logic [1:0] off);
        logic ill;
        case (t)
            SB:      ill = 1'b0;
            SBU:     ill = we;
            SH:      ill = off[0];
            SHU:     ill = off[0] | we;
            SW:      ill = (off != 2'b00);
            default: ill = 1'b1;
        endcase
        return ill;
    endfunction
endpackage

// File: rtl/lsu_ctrl_select_rd.sv
// Load-data extraction: picks the addressed byte/halfword lane and sign- or zero-extends it.
module select_rd
    import rysyPkg::*;
    import selectPkg::*;
(
    input  logic [REG_LEN-1:0] rdata,
    input  sel_type            sel,
    input  logic [1:0]         off,
    output logic [REG_LEN-1:0] rd
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[7:0];
        case (off)
            2'd0: byte_lane = rdata[7:0];
            2'd1: byte_lane = rdata[15:8];
            2'd2: byte_lane = rdata[23:16];
            2'd3: byte_lane = rdata[31:24];
            default: byte_lane = rdata[7:0];
        endcase
        half_lane = off[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        rd = '0;
        case (sel)
            SB:  rd = {{(REG_LEN-8){byte_lane[7]}}, byte_lane};
            SBU: rd = {{(REG_LEN-8){1'b0}}, byte_lane};
            SH:  rd = {{(REG_LEN-16){half_lane[15]}}, half_lane};
            SHU: rd = {{(REG_LEN-16){1'b0}}, half_lane};
            SW:  rd = rdata;
            default: rd = '0;
        endcase
    end
endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one core access, runs a single bus request/response
// handshake and returns a one-cycle completion pulse with extended load data or an error.
module lsu_ctrl
    import rysyPkg::*;
    import selectPkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  sel_type            req_type,
    input  logic [REG_LEN-1:0] req_addr,
    input  logic [REG_LEN-1:0] req_wdata,
    output logic               resp_valid,
    output logic [REG_LEN-1:0] resp_rdata,
    output logic               resp_err,
    output logic               mem_req,
    output logic               mem_we,
    output logic [REG_LEN-1:0] mem_addr,
    output logic [3:0]         mem_be,
    output logic [REG_LEN-1:0] mem_wdata,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [REG_LEN-1:0] mem_rdata
);
    lsu_state_t         state_q, state_d;
    logic               we_q, we_d;
    sel_type            type_q, type_d;
    logic [1:0]         off_q, off_d;
    logic               req_ready_q, req_ready_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [REG_LEN-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]         mem_be_q, mem_be_d;
    logic [REG_LEN-1:0] mem_wdata_q, mem_wdata_d;
    logic               resp_valid_q, resp_valid_d;
    logic               resp_err_q, resp_err_d;
    logic [REG_LEN-1:0] resp_rdata_q, resp_rdata_d;

    logic [3:0]         be_c;
    logic [REG_LEN-1:0] wdata_c;
    logic [REG_LEN-1:0] ld_data;

    select_rd u_select_rd (
        .rdata (mem_rdata),
        .sel   (type_q),
        .off   (off_q),
        .rd    (ld_data)
    );

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = req_wdata;
        case (req_type)
            SB, SBU: begin
                be_c    = 4'b0001 << req_addr[1:0];
                wdata_c = {4{req_wdata[7:0]}};
            end
            SH, SHU: begin
                be_c    = 4'b0011 << req_addr[1:0];
                wdata_c = {2{req_wdata[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = req_wdata;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        type_d       = type_q;
        off_d        = off_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d   = req_we;
                    type_d = req_type;
                    off_d  = req_addr[1:0];
                    if (access_illegal(req_type, req_we, req_addr[1:0])) begin
                        state_d      = ERR;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d     = REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[REG_LEN-1:2], 2'b00};
                        mem_be_d    = be_c;
                        mem_wdata_d = req_we ? wdata_c : '0;
                    end
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    if (we_q) begin
                        state_d      = DONE;
                        resp_valid_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d      = DONE;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = ld_data;
                end
            end
            DONE, ERR: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            type_q       <= SB;
            off_q        <= 2'b00;
            req_ready_q  <= 1'b1;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            type_q       <= type_d;
            off_q        <= off_d;
            req_ready_q  <= req_ready_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: scripted bus responder with a behavioural access model and per-cycle compare.
module tb_lsu_ctrl;
    import selectPkg::*;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_we;
    sel_type     req_type;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;

    lsu_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        chk_en = 1'b0;
    logic        exp_ready, exp_mreq, exp_rv, exp_err, exp_we;
    logic [31:0] exp_rdata, exp_addr, exp_wdata;
    logic [3:0]  exp_be;

    int          resp_cnt, mreq_cnt, acc_cyc, resp_cyc;
    logic [31:0] last_rdata, last_addr, last_wdata;
    logic [3:0]  last_be;
    logic        last_we, last_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    // ---- behavioural model of an access ----
    function automatic int m_size(input int t);
        if (t == 0 || t == 3) return 1;
        if (t == 1 || t == 4) return 2;
        return 4;
    endfunction

    function automatic logic m_illegal(input logic we, input int t, input logic [1:0] a);
        if (t == 2 && a != 0) return 1'b1;
        if ((t == 1 || t == 4) && a[0]) return 1'b1;
        if (we && (t == 3 || t == 4)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_be(input int t, input logic [1:0] a);
        int sz = m_size(t);
        if (sz == 4) return 4'hF;
        return 4'(((1 << sz) - 1) << a);
    endfunction

    function automatic logic [31:0] m_wdata(input int t, input logic [31:0] w);
        int sz = m_size(t);
        if (sz == 1) return (w & 32'hFF) * 32'h01010101;
        if (sz == 2) return (w & 32'hFFFF) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(input int t, input logic [1:0] a, input logic [31:0] r);
        int sz = m_size(t);
        int lane;
        logic [63:0] v, mask;
        if (sz == 4) return r;
        lane = (sz == 2) ? (a & 2) : a;
        v = {32'd0, r} >> (8 * lane);
        mask = (64'd1 << (8 * sz)) - 64'd1;
        v = v & mask;
        if ((t == 0 || t == 1) && v[8*sz-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic set_exp(input logic rdy, input logic mr, input logic rv, input logic er, input logic [31:0] rd);
        exp_ready = rdy; exp_mreq = mr; exp_rv = rv; exp_err = er; exp_rdata = rd;
    endtask

    task automatic noise();
        req_valid = 1'($urandom % 2);
        req_we    = 1'($urandom % 2);
        req_type  = sel_type'(3'($urandom % 5));
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    // ---- single compare process ----
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", req_ready, exp_ready);
            chk("mem_req", mem_req, exp_mreq);
            chk("resp_valid", resp_valid, exp_rv);
            chk("mem_addr_lsb", mem_addr[1:0], 0);
            if (exp_rv) begin
                chk("resp_err", resp_err, exp_err);
                chk("resp_rdata", resp_rdata, exp_rdata);
            end
            if (exp_mreq) begin
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_be", mem_be, exp_be);
                chk("mem_we", mem_we, exp_we);
                if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
            end
        end
    end

    always @(negedge clk) begin
        if (resp_valid) begin
            resp_cnt++; last_rdata = resp_rdata; last_err = resp_err; resp_cyc = cyc;
        end
        if (mem_req) begin
            mreq_cnt++; last_addr = mem_addr; last_be = mem_be; last_we = mem_we; last_wdata = mem_wdata;
        end
    end

    // Entered and left at posedge+1 with the controller idle.
    task automatic run_access(input logic we, input int t, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int gd, input int rd);
        logic ill;
        ill = m_illegal(we, t, addr[1:0]);
        resp_cnt = 0; mreq_cnt = 0;
        req_valid = 1'b1; req_we = we; req_type = sel_type'(3'(t));
        req_addr = addr; req_wdata = wdata; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        set_exp(1, 0, 0, 0, 0);
        acc_cyc = cyc;
        @(posedge clk); #1;
        if (ill) begin
            noise(); set_exp(0, 0, 1, 1, 0);
            @(posedge clk); #1;
        end else begin
            exp_addr = {addr[31:2], 2'b00}; exp_be = m_be(t, addr[1:0]);
            exp_we = we; exp_wdata = m_wdata(t, wdata);
            for (int k = 0; k <= gd; k++) begin
                noise(); set_exp(0, 1, 0, 0, 0);
                mem_gnt = (k == gd);
                mem_rvalid = (k != gd) ? 1'($urandom % 2) : 1'b0;
                mem_rdata = $urandom;
                @(posedge clk); #1;
            end
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            if (!we) begin
                for (int k = 0; k <= rd; k++) begin
                    noise(); set_exp(0, 0, 0, 0, 0);
                    mem_rvalid = (k == rd);
                    mem_gnt = (k != rd) ? 1'($urandom % 2) : 1'b0;
                    mem_rdata = (k == rd) ? rdata : $urandom;
                    @(posedge clk); #1;
                end
            end
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            noise(); set_exp(0, 0, 1, 0, we ? 32'd0 : m_load(t, addr[1:0], rdata));
            @(posedge clk); #1;
        end
        req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        set_exp(1, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_type = SB;
        req_addr = '0; req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        set_exp(1, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", req_ready, 1);
        chk_en = 1'b1;

        // LB 0x103
        run_access(0, 0, 32'h103, 0, 32'h80112233, 0, 0);
        chk("lb_addr", last_addr, 32'h100);
        chk("lb_be", last_be, 4'b1000);
        chk("lb_rdata", last_rdata, 32'hFFFFFF80);
        chk("lb_lat", resp_cyc - acc_cyc, 3);
        // LHU 0x202
        run_access(0, 4, 32'h202, 0, 32'h9ABC1234, 0, 0);
        chk("lhu_be", last_be, 4'b1100);
        chk("lhu_rdata", last_rdata, 32'h00009ABC);
        // SB 0x301
        run_access(1, 0, 32'h301, 32'h000000A5, 0, 0, 0);
        chk("sb_wdata", last_wdata, 32'hA5A5A5A5);
        chk("sb_be", last_be, 4'b0010);
        chk("sb_we", last_we, 1);
        chk("sb_lat", resp_cyc - acc_cyc, 2);
        // SW misaligned, SBU store
        run_access(1, 2, 32'h402, 32'h12345678, 0, 0, 0);
        chk("sw_err", last_err, 1);
        chk("sw_lat", resp_cyc - acc_cyc, 1);
        chk("sw_nomreq", mreq_cnt, 0);
        run_access(1, 3, 32'h404, 32'h55, 0, 0, 0);
        chk("sbu_err", last_err, 1);
        chk("sbu_lat", resp_cyc - acc_cyc, 1);
        chk("sbu_nomreq", mreq_cnt, 0);
        // LW with slow grant and slow data
        run_access(0, 2, 32'h500, 0, 32'hDEADBEEF, 3, 2);
        chk("lw_mreq_cycles", mreq_cnt, 4);
        chk("lw_resp_count", resp_cnt, 1);
        chk("lw_rdata", last_rdata, 32'hDEADBEEF);

        for (int i = 0; i < 60; i++) begin
            run_access(1'($urandom % 2), int'($urandom % 5), $urandom, $urandom, $urandom,
                       int'($urandom % 4), int'($urandom % 4));
            repeat ($urandom % 3) begin
                @(posedge clk); #1;
            end
        end

        // Reset while a request is outstanding on the bus
        chk_en = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_type = SW; req_addr = 32'h600;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rreq_mem_req_pre", mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rreq_mem_req", mem_req, 0);
        chk("rreq_mem_be", mem_be, 0);
        chk("rreq_mem_addr", mem_addr, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        chk("rreq_mem_req_post", mem_req, 0);
        chk("rreq_ready", req_ready, 1);

        // Reset while waiting for read data, then a late rvalid
        req_valid = 1'b1; req_we = 1'b0; req_type = SW; req_addr = 32'h700;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        chk("rwait_ready_busy", req_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rwait_mem_req", mem_req, 0);
        chk("rwait_resp_valid", resp_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        repeat (3) begin
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            chk("rwait_no_resp", resp_valid, 0);
            chk("rwait_ready", req_ready, 1);
        end

        set_exp(1, 0, 0, 0, 0);
        chk_en = 1'b1;
        run_access(0, 1, 32'h802, 0, 32'h8001_7FFF, 1, 1);
        chk("recover_rdata", last_rdata, 32'hFFFF8001);
        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
